// File: rtl/dram_pkg.sv
// Shared DRAM data-path definitions: default bus width and the word type.
package dram_pkg;

   localparam int DRAM_DATA_WIDTH = 8;

   typedef logic [DRAM_DATA_WIDTH-1:0] dram_word_t;

endpackage

// File: rtl/dram_sipo_bitcnt.sv
// Bit counter for dram_sipo: counts 0..WIDTH-1, wraps to 0, flags the wrap cycle.
module dram_sipo_bitcnt #(
   parameter int WIDTH = 8
) (
   input  logic clk,
   input  logic rst,
   output logic tc
);

   localparam int CNT_W = $clog2(WIDTH);

   logic [CNT_W-1:0] cnt;

   // tc is high while the counter sits on its last value, so the next edge wraps
   assign tc = (cnt == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (tc) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/dram_sipo.sv
// Serial-in, parallel-out deserialiser for DRAM read data.
// Optional word_valid strobe and bit counter enabled by macro DRAM_SIPO_VALID_EN.
module dram_sipo
   import dram_pkg::*;
#(
   parameter int WIDTH     = DRAM_DATA_WIDTH,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             data_in,
   output logic [WIDTH-1:0] data_out
`ifdef DRAM_SIPO_VALID_EN
   ,
   output logic             word_valid
`endif
);

   logic [WIDTH-1:0] sr;

   // rst_b is active-high despite its name
   generate
      if (MSB_FIRST) begin : g_msb_first
         always_ff @(posedge clk) begin
            if (rst_b) begin
               sr <= '0;
            end else begin
               sr <= {sr[WIDTH-2:0], data_in};
            end
         end
      end else begin : g_lsb_first
         always_ff @(posedge clk) begin
            if (rst_b) begin
               sr <= '0;
            end else begin
               sr <= {data_in, sr[WIDTH-1:1]};
            end
         end
      end
   endgenerate

   assign data_out = sr;

`ifdef DRAM_SIPO_VALID_EN
   logic tc;

   dram_sipo_bitcnt #(
      .WIDTH (WIDTH)
   ) u_bitcnt (
      .clk (clk),
      .rst (rst_b),
      .tc  (tc)
   );

   // Registering tc lines the strobe up with the cycle that shows the full word
   always_ff @(posedge clk) begin
      if (rst_b) begin
         word_valid <= 1'b0;
      end else begin
         word_valid <= tc;
      end
   end
`endif

endmodule

// File: tb/tb_dram_sipo.sv
// Directed bench for dram_sipo: one MSB-first and one LSB-first instance on shared inputs.
module tb_dram_sipo;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_b = 1'b1;
   logic         data_in = 1'b0;
   logic [W-1:0] dout_m;
   logic [W-1:0] dout_l;
`ifdef DRAM_SIPO_VALID_EN
   logic         wv_m;
   logic         wv_l;
`endif

   int n_cmp  = 0;
   int n_fail = 0;
   int edges  = 0;
   int pulses = 0;
   logic hist_q[$];

   always #5 clk = ~clk;

   dram_sipo #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
      .clk        (clk),
      .rst_b      (rst_b),
      .data_in    (data_in),
      .data_out   (dout_m)
`ifdef DRAM_SIPO_VALID_EN
      ,
      .word_valid (wv_m)
`endif
   );

   dram_sipo #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
      .clk        (clk),
      .rst_b      (rst_b),
      .data_in    (data_in),
      .data_out   (dout_l)
`ifdef DRAM_SIPO_VALID_EN
      ,
      .word_valid (wv_l)
`endif
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Expected word from sample history: hist_q[0] is the newest sample
   function automatic logic [W-1:0] model_word(input bit msb_first);
      logic [W-1:0] e;
      e = '0;
      for (int i = 0; i < W; i++) begin
         if (i < hist_q.size()) begin
            if (msb_first) e[i] = hist_q[i];
            else           e[W-1-i] = hist_q[i];
         end
      end
      return e;
   endfunction

   task automatic do_reset(input int cycles);
      rst_b   = 1'b1;
      data_in = 1'b1;
      repeat (cycles) @(posedge clk);
      #1;
      rst_b = 1'b0;
      hist_q.delete();
      edges = 0;
   endtask

   task automatic shift(input logic d);
      data_in = d;
      @(posedge clk);
      #1;
      hist_q.push_front(d);
      if (hist_q.size() > W) void'(hist_q.pop_back());
      edges++;
   endtask

   task automatic check_model(input string tag);
      check({tag, "_msb"}, dout_m, model_word(1'b1));
      check({tag, "_lsb"}, dout_l, model_word(1'b0));
`ifdef DRAM_SIPO_VALID_EN
      check({tag, "_wv_msb"}, {7'd0, wv_m}, {7'd0, (edges % W) == 0});
      check({tag, "_wv_lsb"}, {7'd0, wv_l}, {7'd0, (edges % W) == 0});
`endif
   endtask

   task automatic shift_byte(input logic [W-1:0] bits, input string tag);
      // bits[W-1] is sent first
      for (int i = W - 1; i >= 0; i--) begin
         shift(bits[i]);
         check_model(tag);
      end
   endtask

   initial begin
      logic [W-1:0] pat;

      // Reset held two cycles with data_in high
      do_reset(2);
      check("reset_msb", dout_m, 8'h00);
      check("reset_lsb", dout_l, 8'h00);
`ifdef DRAM_SIPO_VALID_EN
      check("reset_wv", {7'd0, wv_m}, 8'h00);
`endif

      // Partial word: 1,0,1 -> zeros in unfilled positions
      shift(1'b1); shift(1'b0); shift(1'b1);
      check("part_msb", dout_m, 8'h05);
      check("part_lsb", dout_l, 8'hA0);
      shift(1'b0); shift(1'b0); shift(1'b1); shift(1'b0); shift(1'b1);
      check("a5_msb", dout_m, 8'hA5);
      check("a5_lsb", dout_l, 8'hA5);
`ifdef DRAM_SIPO_VALID_EN
      check("a5_wv", {7'd0, wv_m}, 8'h01);
`endif

      // Next word back-to-back: 1,1,0,0,0,0,0,0
      pat = 8'hC0;
      shift_byte(pat, "w2");
      check("w2_msb", dout_m, 8'hC0);
      check("w2_lsb", dout_l, 8'h03);

      // One extra bit: the strobe must drop after a single cycle
      shift(1'b1);
      check_model("w3_first");
      check("w3_msb", dout_m, 8'h81);
      check("w3_lsb", dout_l, 8'h81);

      // Mid-word reset discards a partial word
      do_reset(1);
      check("mid_rst_msb", dout_m, 8'h00);
      check("mid_rst_lsb", dout_l, 8'h00);
      for (int i = 0; i < 5; i++) begin
         shift(i[0] ? 1'b0 : 1'b1);
         check_model("mid_pre");
      end
      do_reset(1);
      check("mid_rst2_msb", dout_m, 8'h00);
`ifdef DRAM_SIPO_VALID_EN
      check("mid_rst2_wv", {7'd0, wv_m}, 8'h00);
`endif
      pat = 8'hFF;
      for (int i = 0; i < W - 1; i++) begin
         shift(1'b1);
         check_model("mid_ff");
      end
      check("mid_7_msb", dout_m, 8'h7F);
      check("mid_7_lsb", dout_l, 8'hFE);
      shift(1'b1);
      check_model("mid_ff8");
      check("mid_ff_msb", dout_m, pat);
      check("mid_ff_lsb", dout_l, pat);

      // Random regression, 100 bits after a fresh reset
      do_reset(1);
      pulses = 0;
      for (int i = 0; i < 100; i++) begin
         shift(1'($urandom_range(0, 1)));
         check_model("rand");
`ifdef DRAM_SIPO_VALID_EN
         if (wv_m === 1'b1) pulses++;
`endif
      end
`ifdef DRAM_SIPO_VALID_EN
      check("rand_pulses", 8'(pulses), 8'd12);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/dram_sipo.md
# dram_sipo

Serial-in, parallel-out shift register for the DRAM controller data path. Captures one bit per clock from `data_in` and presents the last `WIDTH` captured bits on `data_out`. It deserialises single-bit read data into bus-width words for the controller's read-return logic. An optional word-boundary strobe marks each complete word.

## Interface
- `WIDTH`, default 8: parallel word width in bits; legal range is 2 or more.
- `MSB_FIRST`, default 1: bit ordering.
  - 1: the first-received bit of a word ends up in `data_out[WIDTH-1]`.
  - 0: the first-received bit ends up in `data_out[0]`.
- `clk` input, 1 bit: the single clock; all state updates on its rising edge.
- `rst_b` input, 1 bit: reset. It is synchronous and active-high; despite the name, 1 means reset.
- `data_in` input, 1 bit: serial data, sampled on every rising edge when not in reset.
- `data_out` output, `WIDTH` bits: the shift register contents, registered.
- `word_valid` output, 1 bit: present only when `DRAM_SIPO_VALID_EN` is defined (see Configuration).

## Operation
- Internal state is a `WIDTH`-bit shift register `sr`, which drives `data_out` directly with no output logic.
- Reset (`rst_b`=1 at a rising edge):
  - `sr` is cleared to 0.
  - The bit counter, if present, is cleared to 0.
  - `word_valid` is 0.
- Otherwise, at each rising edge:
  - With `MSB_FIRST`=1: `sr` becomes `{sr[WIDTH-2:0], data_in}`.
  - With `MSB_FIRST`=0: `sr` becomes `{data_in, sr[WIDTH-1:1]}`.
- Shifting is free-running, with no enable. `data_out` changes every cycle and always shows the most recent `WIDTH` samples.
- X or Z on `data_in` is shifted in unchanged; there is no filtering. While reset is held, `data_in` is ignored.
- Reset asserted mid-word discards the partial word. After reset is released, the next sampled bit is bit 0 of a new word.

## Timing
- Latency: a bit sampled at edge N is visible at `data_out[0]` (MSB_FIRST=1) or `data_out[WIDTH-1]` (MSB_FIRST=0) immediately after edge N.
- A full word captured at edges N-WIDTH+1 through N is valid on `data_out` from after edge N until edge N+1.
- The first word after reset release is complete after `WIDTH` edges with `rst_b`=0.
- Before that point, `data_out` holds zeros in the bit positions not yet filled.
- Reset takes effect at the edge where `rst_b`=1. There is no asynchronous path.

## Configuration
- Macro `DRAM_SIPO_VALID_EN`.
- Defined:
  - Adds a bit counter of width `$clog2(WIDTH)` that counts from 0 to `WIDTH-1` and wraps to 0.
  - Adds the registered `word_valid` output.
  - `word_valid` is 1 in exactly the cycle after the edge where the counter wraps from `WIDTH-1` to 0, i.e. it coincides with `data_out` holding a complete word.
  - Back-to-back words give a `word_valid` pulse every `WIDTH` cycles.
  - The counter and `word_valid` clear on reset.
- Not defined: no counter and no `word_valid` port. The port list is exactly `clk`, `rst_b`, `data_in`, `data_out`.

## Structure
- Shared package `dram_pkg`:
  - `DRAM_DATA_WIDTH` (8), used as the `WIDTH` default by instantiating modules.
  - `dram_word_t` typedef (`logic [DRAM_DATA_WIDTH-1:0]`).
- One sub-module, `dram_sipo_bitcnt`: a wrap-at-`WIDTH` counter with a terminal-count output. It is instantiated only under `DRAM_SIPO_VALID_EN`.
- The shift register stays in `dram_sipo`, with one generate branch per `MSB_FIRST` value.

## Test plan
- Reset: hold `rst_b`=1 for 2 cycles with `data_in`=1 -> `data_out`=8'h00, and `word_valid`=0 when enabled.
- MSB-first word, `WIDTH`=8, `MSB_FIRST`=1: release reset, send 1,0,1,0,0,1,0,1 on consecutive edges -> `data_out`=8'hA5 after the 8th edge.
- LSB-first word, `MSB_FIRST`=0: send the same sequence -> `data_out`=8'hA5 bit-reversed = 8'hA5 (palindrome). Then send 1,1,0,0,0,0,0,0 -> 8'h03.
- Valid strobe (macro defined): 100 random bits after reset -> `word_valid` pulses after edges 8, 16, ..., 96, 12 pulses in total. Each pulse matches a reference model's packed word.
- Mid-word reset: send 5 bits, assert `rst_b` for 1 cycle, then send 8'hFF serially -> `data_out`=8'hFF after 8 more edges, and the first `word_valid` is at the 8th post-reset edge.
- Random regression: 100 cycles of random `data_in` -> after every edge, `data_out` equals the last 8 samples packed per `MSB_FIRST`.
